vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_ctrl.sv | 47 ++++
 tb/tb_vga_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing: 640x480@60 timing constants and derived active-window bounds,
// shared by vga_ctrl and the picture generator.
package vga_timing;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BACK   = 10'd40;
  localparam logic [9:0] H_LEFT   = 10'd8;
  localparam logic [9:0] H_VALID  = 10'd640;
  localparam logic [9:0] H_RIGHT  = 10'd8;
  localparam logic [9:0] H_FRONT  = 10'd8;
  localparam logic [9:0] H_TOTAL  = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd25;
  localparam logic [9:0] V_TOP    = 10'd8;
  localparam logic [9:0] V_VALID  = 10'd480;
  localparam logic [9:0] V_BOTTOM = 10'd8;
  localparam logic [9:0] V_FRONT  = 10'd2;
  localparam logic [9:0] V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam logic [9:0] H_DE_START = H_SYNC + H_BACK + H_LEFT;
  localparam logic [9:0] H_DE_END   = H_DE_START + H_VALID;
  localparam logic [9:0] V_DE_START = V_SYNC + V_BACK + V_TOP;
  localparam logic [9:0] V_DE_END   = V_DE_START + V_VALID;
  function automatic logic in_range(logic [9:0] val, logic [9:0] lo, logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction
endpackage

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA sync/counter generator; requests pixels one clock ahead of
// the active window so a registered picture generator lines up with rgb.
module vga_ctrl
  import vga_timing::*;
#(
  parameter logic [9:0] VSYNC_N     = V_SYNC,
  parameter logic [9:0] VTOTAL_N    = V_TOTAL,
  parameter logic [9:0] VDE_START_N = V_DE_START,
  parameter logic [9:0] VDE_END_N   = V_DE_END
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
);
  logic [9:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic       line_end, v_act, rgb_valid, pix_data_req;
  assign line_end = cnt_h_q == H_TOTAL - 10'd1;
  always_comb begin
    cnt_h_d = line_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d = !line_end ? cnt_v_q : (cnt_v_q == VTOTAL_N - 10'd1) ? 10'd0 : cnt_v_q + 10'd1;
  end
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end
  // request window leads the valid window by one clock for the generator's register
  assign v_act        = in_range(cnt_v_q, VDE_START_N, VDE_END_N);
  assign rgb_valid    = v_act && in_range(cnt_h_q, H_DE_START, H_DE_END);
  assign pix_data_req = v_act && in_range(cnt_h_q, H_DE_START - 10'd1, H_DE_END - 10'd1);
  assign hsync        = cnt_h_q < H_SYNC;
  assign vsync        = cnt_v_q < VSYNC_N;
  assign pix_x        = pix_data_req ? cnt_h_q - (H_DE_START - 10'd1) : 10'h3FF;
  assign pix_y        = pix_data_req ? cnt_v_q - VDE_START_N : 10'h3FF;
  assign rgb          = rgb_valid ? pix_data : 16'h0000;
  assign frame_start  = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: directed vector table plus reset/wrap/window-count sequences,
// using a shortened 13-line frame (active rows 6..9) to keep runtime small.
module tb_vga_ctrl;
  localparam int HT = 800;
  localparam int VT = 13;
  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, frame_start;
  logic [15:0] rgb;
  int n_pass = 0;
  int n_total = 0;
  int mh = 0;
  int mv = 0;

  vga_ctrl #(
    .VSYNC_N(10'd2), .VTOTAL_N(10'd13), .VDE_START_N(10'd6), .VDE_END_N(10'd10)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frame_start)
  );

  always #20 vga_clk = ~vga_clk;
  always @(posedge vga_clk) pix_data <= {pix_y[5:0], pix_x};

  typedef struct {
    int h; int v;
    logic hs; logic vs;
    logic [9:0] px; logic [9:0] py;
    logic [15:0] rgb; logic fs;
  } vec_t;

  function automatic vec_t mk(int h, int v, logic hs, logic vs, logic [9:0] px,
                              logic [9:0] py, logic [15:0] c, logic fs);
    vec_t r;
    r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.px = px; r.py = py; r.rgb = c; r.fs = fs;
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    mh = (mh == HT - 1) ? 0 : mh + 1;
    if (mh == 0) mv = (mv == VT - 1) ? 0 : mv + 1;
  endtask

  task automatic goto(int h, int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 30000) begin
      step();
      n++;
    end
    if (!(mh == h && mv == v)) begin
      n_total++;
      $display("FAIL goto(%0d,%0d): timeout, model at %0d,%0d", h, v, mh, mv);
    end
  endtask

  task automatic chk_all(string tag, vec_t e);
    chk({tag, ".hsync"}, {15'd0, hsync}, {15'd0, e.hs});
    chk({tag, ".vsync"}, {15'd0, vsync}, {15'd0, e.vs});
    chk({tag, ".pix_x"}, {6'd0, pix_x}, {6'd0, e.px});
    chk({tag, ".pix_y"}, {6'd0, pix_y}, {6'd0, e.py});
    chk({tag, ".rgb"}, rgb, e.rgb);
    chk({tag, ".frame_start"}, {15'd0, frame_start}, {15'd0, e.fs});
  endtask

  initial begin
    vec_t tbl[20];
    int hs_cnt, vs_cnt, fs_cnt;
    tbl[0]  = mk(1,   0,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[1]  = mk(95,  0,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[2]  = mk(96,  0,  0, 1, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[3]  = mk(0,   1,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[4]  = mk(0,   2,  1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[5]  = mk(300, 5,  0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[6]  = mk(142, 6,  0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[7]  = mk(143, 6,  0, 0, 10'd0,   10'd0,   16'h0000, 0);
    tbl[8]  = mk(144, 6,  0, 0, 10'd1,   10'd0,   16'h0000, 0);
    tbl[9]  = mk(145, 6,  0, 0, 10'd2,   10'd0,   16'h0001, 0);
    tbl[10] = mk(782, 6,  0, 0, 10'd639, 10'd0,   16'h027E, 0);
    tbl[11] = mk(783, 6,  0, 0, 10'h3FF, 10'h3FF, 16'h027F, 0);
    tbl[12] = mk(784, 6,  0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[13] = mk(300, 7,  0, 0, 10'd157, 10'd1,   16'h049C, 0);
    tbl[14] = mk(300, 9,  0, 0, 10'd157, 10'd3,   16'h0C9C, 0);
    tbl[15] = mk(300, 10, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[16] = mk(799, 12, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[17] = mk(0,   0,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1);
    tbl[18] = mk(1,   0,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 0);
    tbl[19] = mk(0,   0,  1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1);
    repeat (10) @(posedge vga_clk);
    #1;
    chk_all("reset", mk(0, 0, 1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1));
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    mh = 0;
    mv = 0;
    for (int i = 0; i < 19; i++) begin
      goto(tbl[i].h, tbl[i].v);
      chk_all($sformatf("vec%0d(%0d,%0d)", i, tbl[i].h, tbl[i].v), tbl[i]);
    end
    goto(0, 1);
    hs_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      if (hsync) hs_cnt++;
      step();
    end
    chk("hsync_per_line", 16'(hs_cnt), 16'd96);
    goto(0, 0);
    vs_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (vsync) vs_cnt++;
      if (frame_start) fs_cnt++;
      step();
    end
    chk("vsync_per_frame", 16'(vs_cnt), 16'd1600);
    chk("frame_start_per_frame", 16'(fs_cnt), 16'd1);
    chk("frame_start_period", {15'd0, frame_start}, 16'd1);
    goto(400, 8);
    chk("pre_reset.pix_x", {6'd0, pix_x}, 16'd257);
    sys_rst_n = 1'b0;
    #1;
    chk_all("async_reset", mk(0, 0, 1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1));
    repeat (3) @(posedge vga_clk);
    #1;
    chk_all("reset_hold", mk(0, 0, 1, 1, 10'h3FF, 10'h3FF, 16'h0000, 1));
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    mh = 0;
    mv = 0;
    step();
    chk_all("restart(1,0)", tbl[18]);
    goto(96, 0);
    chk("restart.hsync_drop", {15'd0, hsync}, 16'd0);
    goto(0, 6);
    goto(143, 6);
    chk("restart.pix_x_first", {6'd0, pix_x}, 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
